// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// State encoding, constant-width math and the row priority encoder live here.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      HELD,
      DEB_RELEASE
   } kp_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r++;
      return r;
   endfunction

   // Lowest set bit wins, so several closed rows in one column resolve to the lowest row.
   function automatic int unsigned lowest_set(input logic [31:0] v);
      int unsigned r;
      logic found;
      r = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (v[i] && !found) begin
            r = i;
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the scanner, grouped as one bundle.
// master = scanner, slave = keypad model plus consuming controller.
interface keypad_scanner_if
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4
) ();

   localparam int unsigned CODE_W = clog2(ROWS * COLS);

   logic [ROWS-1:0]   row;
   logic [COLS-1:0]   col;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready;
   logic              overrun;
   logic              busy;

   modport master (
      input  row, key_ready,
      output col, key_code, key_valid, overrun, busy
   );

   modport slave (
      output row, key_ready,
      input  col, key_code, key_valid, overrun, busy
   );

endinterface

// File: rtl/key_debounce_counter.sv
// Compare-and-count block: counts consecutive edges where sample equals the reference
// pattern; 'last' flags the edge whose increment reaches TERMINAL.
module key_debounce_counter #(
   parameter int unsigned W        = 4,
   parameter int unsigned CW       = 3,
   parameter int unsigned TERMINAL = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         start,
   input  logic         enable,
   input  logic [W-1:0] sample,
   input  logic [W-1:0] ref_pat,
   output logic         match,
   output logic         last
);

   localparam logic [CW-1:0] TERM_M1 = CW'(TERMINAL - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] count;

   assign match = (sample == ref_pat);
   assign last  = enable && match && (count >= TERM_M1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (start) begin
         count <= CW'(1);
      end else if (enable && match && (count != CNT_MAX)) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Clocked matrix-keypad scanner: one-hot column strobe, press/release debounce,
// binary key code over a valid/ready handshake with overrun reporting.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 4,
   parameter int unsigned SCAN_HOLD       = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master bus
);

   localparam int unsigned CODE_W  = clog2(ROWS * COLS);
   localparam int unsigned CIW     = clog2(COLS);
   localparam int unsigned CNT_TOP = (SCAN_HOLD > DEBOUNCE_CYCLES) ? SCAN_HOLD : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = clog2(CNT_TOP + 1);

   localparam logic [CW-1:0]  HOLD_LAST = CW'(SCAN_HOLD - 1);
   localparam logic [CIW-1:0] COL_LAST  = CIW'(COLS - 1);

   kp_state_e         state, state_n;
   logic [CIW-1:0]    col_idx;
   logic [CW-1:0]     hold_cnt;
   logic [ROWS-1:0]   row_snap;
   logic [ROWS-1:0]   acc_rows;
   logic [ROWS-1:0]   dc_ref;
   logic [CODE_W-1:0] key_code;
   logic [CODE_W-1:0] code_new;
   logic              key_valid;
   logic              overrun;
   logic              accept;
   logic              dc_start, dc_clear, dc_en, dc_match, dc_last;
   logic              col_adv, hold_rst, hold_inc;

   assign bus.col       = COLS'(1) << col_idx;
   assign bus.key_code  = key_code;
   assign bus.key_valid = key_valid;
   assign bus.overrun   = overrun;
   assign bus.busy      = (state != SCAN);

   // One counter serves both phases: press compares against the snapshot, release against zero.
   assign dc_ref = (state == DEB_PRESS) ? row_snap : '0;

   key_debounce_counter #(
      .W        (ROWS),
      .CW       (CW),
      .TERMINAL (DEBOUNCE_CYCLES)
   ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .clear   (dc_clear),
      .start   (dc_start),
      .enable  (dc_en),
      .sample  (bus.row),
      .ref_pat (dc_ref),
      .match   (dc_match),
      .last    (dc_last)
   );

   // On the detect edge the snapshot is not yet registered, so take the live rows.
   assign acc_rows = (state == SCAN) ? bus.row : row_snap;
   assign code_new = CODE_W'(lowest_set(32'(acc_rows)) * COLS + 32'(col_idx));

   always_ff @(posedge clk) begin
      if (rst) state <= SCAN;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      dc_start = 1'b0;
      dc_clear = 1'b0;
      dc_en    = 1'b0;
      col_adv  = 1'b0;
      hold_rst = 1'b0;
      hold_inc = 1'b0;
      case (state)
         SCAN: begin
            if (bus.row != '0) begin
               dc_start = 1'b1;
               if (DEBOUNCE_CYCLES <= 1) begin
                  accept   = 1'b1;
                  dc_clear = 1'b1;
                  state_n  = HELD;
               end else begin
                  state_n = DEB_PRESS;
               end
            end else if (hold_cnt >= HOLD_LAST) begin
               col_adv  = 1'b1;
               hold_rst = 1'b1;
            end else begin
               hold_inc = 1'b1;
            end
         end
         DEB_PRESS: begin
            dc_en = 1'b1;
            if (!dc_match) begin
               dc_clear = 1'b1;
               hold_rst = 1'b1;
               state_n  = SCAN;
            end else if (dc_last) begin
               accept   = 1'b1;
               dc_clear = 1'b1;
               state_n  = HELD;
            end
         end
         HELD: begin
            if (bus.row == '0) begin
               dc_start = 1'b1;
               if (DEBOUNCE_CYCLES <= 1) begin
                  dc_clear = 1'b1;
                  col_adv  = 1'b1;
                  hold_rst = 1'b1;
                  state_n  = SCAN;
               end else begin
                  state_n = DEB_RELEASE;
               end
            end
         end
         DEB_RELEASE: begin
            dc_en = 1'b1;
            if (!dc_match) begin
               dc_clear = 1'b1;
               state_n  = HELD;
            end else if (dc_last) begin
               dc_clear = 1'b1;
               col_adv  = 1'b1;
               hold_rst = 1'b1;
               state_n  = SCAN;
            end
         end
         default: state_n = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_idx   <= '0;
         hold_cnt  <= '0;
         row_snap  <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (state == SCAN && bus.row != '0) row_snap <= bus.row;
         if (col_adv) col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
         if (hold_rst)      hold_cnt <= '0;
         else if (hold_inc) hold_cnt <= hold_cnt + CW'(1);
         // A same-edge handshake frees the slot, so the new key loads instead of overrunning.
         if (accept) begin
            if (!key_valid || bus.key_ready) begin
               key_code  <= code_new;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && bus.key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a virtual keypad drives the rows from the strobed
// column; expected codes are queued at stimulus time and checked by an independent monitor.
module tb_keypad_scanner;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam int unsigned SH   = 2;
   localparam int unsigned DEB  = 4;

   logic clk;
   logic rst;
   logic direct;
   logic [ROWS-1:0] row_drv;
   logic [ROWS-1:0] kp_rows;
   logic pressed [ROWS][COLS];

   int tests;
   int fails;
   int ov_seen;
   int ov_exp;
   int exp_q[$];

   logic        prev_valid;
   logic        prev_take;
   logic [31:0] prev_code;

   keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   keypad_scanner #(
      .ROWS            (ROWS),
      .COLS            (COLS),
      .SCAN_HOLD       (SH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Virtual keypad: a closed key shorts its column strobe onto its row return.
   always_comb begin
      kp_rows = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r][c] && bus.col[c]) kp_rows[r] = 1'b1;
   end

   assign bus.row = direct ? row_drv : kp_rows;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond(input int unsigned sel);
      case (sel)
         0:       return bus.busy == 1'b1;
         1:       return bus.key_valid == 1'b1;
         2:       return bus.busy == 1'b0;
         default: return bus.overrun == 1'b1;
      endcase
   endfunction

   task automatic wait_until(input int unsigned sel, input string nm);
      for (int unsigned i = 0; i < 60; i++) begin
         cyc();
         if (cond(sel)) return;
      end
      tests++;
      fails++;
      $display("FAIL timeout_%s: not seen in 60 cycles, required within 60", nm);
   endtask

   task automatic wait_col(input logic [COLS-1:0] target);
      for (int unsigned i = 0; i < 60; i++) begin
         cyc();
         if (bus.col == target) return;
      end
      tests++;
      fails++;
      $display("FAIL timeout_col: col=0x%0h, required 0x%0h within 60 cycles", bus.col, target);
   endtask

   task automatic clear_keys();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            pressed[r][c] = 1'b0;
   endtask

   // Monitor: every accepted transfer must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.overrun) ov_seen++;
         if (bus.key_valid && prev_valid && !prev_take)
            chk("code_stable", 32'(bus.key_code), prev_code);
         if (bus.key_valid && bus.key_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_key: got code %0d, required no transfer", bus.key_code);
            end else begin
               chk("key_code_xfer", 32'(bus.key_code), 32'(exp_q.pop_front()));
            end
         end
      end
      prev_valid = bus.key_valid;
      prev_take  = bus.key_valid && bus.key_ready;
      prev_code  = 32'(bus.key_code);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rep;
      tests = 0; fails = 0; ov_seen = 0; ov_exp = 0;
      prev_valid = 1'b0; prev_take = 1'b0; prev_code = '0;
      clear_keys();
      rst = 1'b1; direct = 1'b1; row_drv = 4'b0100; bus.key_ready = 1'b0;

      // Reset, then free-running column rotation
      repeat (3) cyc();
      chk("rst_col", 32'(bus.col), 32'h1);
      chk("rst_valid", 32'(bus.key_valid), 0);
      chk("rst_overrun", 32'(bus.overrun), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      rst = 1'b0; row_drv = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         logic [COLS-1:0] one;
         one = 1;
         cyc();
         chk("scan_col", 32'(bus.col), 32'(one << (((i + 1) / SH) % COLS)));
      end

      // Clean press of key 9 (row 2, column 1)
      direct = 1'b0; bus.key_ready = 1'b1;
      exp_q.push_back(9);
      pressed[2][1] = 1'b1;
      wait_until(0, "detect9");
      for (int unsigned e = 0; e < DEB - 1; e++) begin
         chk("lat_valid_low", 32'(bus.key_valid), 0);
         cyc();
      end
      chk("lat_valid_high", 32'(bus.key_valid), 1);
      chk("code9", 32'(bus.key_code), 9);
      chk("frozen_col", 32'(bus.col), 32'h2);
      rep = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         cyc();
         if (bus.key_valid) rep++;
      end
      chk("no_repeat", rep, 0);
      pressed[2][1] = 1'b0;
      repeat (DEB - 1) cyc();
      chk("rel_busy", 32'(bus.busy), 1);
      cyc();
      chk("rel_busy_done", 32'(bus.busy), 0);
      chk("rel_col_next", 32'(bus.col), 32'h4);

      // Bounce during press debounce
      direct = 1'b1;
      wait_col(4'b0100);
      row_drv = 4'b0010;
      cyc();
      chk("bnc_busy", 32'(bus.busy), 1);
      cyc();
      row_drv = '0;
      cyc();
      chk("bnc_scan", 32'(bus.busy), 0);
      chk("bnc_col", 32'(bus.col), 32'h4);
      chk("bnc_valid", 32'(bus.key_valid), 0);
      cyc();
      chk("bnc_hold_restart", 32'(bus.col), 32'h4);
      cyc();
      chk("bnc_col_adv", 32'(bus.col), 32'h8);

      // Multi-row in column 0 resolves to the lowest row
      exp_q.push_back(4);
      wait_col(4'b0001);
      row_drv = 4'b1010;
      wait_until(1, "multi");
      chk("multi_code", 32'(bus.key_code), 4);
      row_drv = '0;
      wait_until(2, "multi_rel");

      // Overrun: key 5 pending, key 14 dropped
      direct = 1'b0; bus.key_ready = 1'b0;
      exp_q.push_back(5);
      pressed[1][1] = 1'b1;
      wait_until(1, "key5");
      chk("code5", 32'(bus.key_code), 5);
      pressed[1][1] = 1'b0;
      wait_until(2, "key5_rel");
      ov_exp++;
      pressed[3][2] = 1'b1;
      wait_until(3, "overrun");
      chk("ovr_code_kept", 32'(bus.key_code), 5);
      chk("ovr_valid", 32'(bus.key_valid), 1);
      cyc();
      chk("ovr_pulse", 32'(bus.overrun), 0);
      pressed[3][2] = 1'b0;
      wait_until(2, "key14_rel");
      bus.key_ready = 1'b1;
      cyc();
      chk("hs_valid_drop", 32'(bus.key_valid), 0);
      bus.key_ready = 1'b0;

      // Reset in the middle of press debounce
      direct = 1'b1; row_drv = 4'b0001;
      wait_until(0, "mid_detect");
      cyc();
      rst = 1'b1; row_drv = '0;
      cyc();
      rst = 1'b0;
      chk("mrst_busy", 32'(bus.busy), 0);
      chk("mrst_valid", 32'(bus.key_valid), 0);
      chk("mrst_col", 32'(bus.col), 32'h1);

      // Reset with an unconsumed key pending
      row_drv = 4'b0001;
      wait_until(1, "pend_key");
      rst = 1'b1; row_drv = '0;
      cyc();
      rst = 1'b0;
      chk("vrst_valid", 32'(bus.key_valid), 0);
      chk("vrst_busy", 32'(bus.busy), 0);
      chk("vrst_col", 32'(bus.col), 32'h1);

      // Random presses: one or two keys in a column, randomly stalled consumer
      direct = 1'b0;
      for (int unsigned it = 0; it < 20; it++) begin
         int unsigned c, r1, r2, nk, lo;
         c  = $urandom_range(0, COLS - 1);
         r1 = $urandom_range(0, ROWS - 1);
         nk = $urandom_range(1, 2);
         r2 = (r1 + 1 + $urandom_range(0, ROWS - 2)) % ROWS;
         lo = (nk == 2 && r2 < r1) ? r2 : r1;
         exp_q.push_back(int'(lo * COLS + c));
         pressed[r1][c] = 1'b1;
         if (nk == 2) pressed[r2][c] = 1'b1;
         repeat ($urandom_range(16, 30)) begin
            bus.key_ready = ($urandom_range(0, 3) != 0);
            cyc();
         end
         clear_keys();
         bus.key_ready = 1'b1;
         repeat ($urandom_range(8, 13)) cyc();
      end
      repeat (4) cyc();

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      chk("overrun_count", 32'(ov_seen), 32'(ov_exp));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised, clocked matrix-keypad scanner. Successor to the team's combinational row-signal keypad model.
- Drives one-hot column strobes, samples the row returns, and debounces both press and release.
- Encodes the pressed key as a binary code and presents it through a valid/ready handshake, with overrun reporting.
- Sits between the physical keypad (or the row-signal model in simulation) and the consuming controller.

Parameters:
- ROWS, 4, number of keypad rows (≥2)
- COLS, 4, number of keypad columns (≥2)
- SCAN_HOLD, 2, cycles each column strobe stays asserted while scanning (≥1)
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- row  in  ROWS  active-high row returns; row[r]=1 means a key at (r, active column) is closed
- col  out  COLS  one-hot active-high column strobe
- key_code  out  CODE_W  CODE_W=clog2(ROWS*COLS); code = row_idx*COLS + col_idx
- key_valid  out  1  key_code holds an unconsumed key
- key_ready  in  1  consumer accepts key_code when key_valid & key_ready
- overrun  out  1  one-cycle pulse: a debounced key was dropped because key_valid was still high
- busy  out  1  high in any state other than SCAN

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. rst dominates all other inputs on any edge, including mid-debounce and with key_valid pending.
- Reset values: col = 1 (column 0), key_code = 0, key_valid = 0, overrun = 0, busy = 0, state = SCAN, all counters 0.
- SCAN state:
  - col rotates left every SCAN_HOLD cycles; wraps from column COLS-1 back to column 0.
  - row is sampled every edge.
  - The first edge with row≠0 latches row_snap=row and col_idx, sets cnt=1, freezes col, and enters DEB_PRESS.
- DEB_PRESS state:
  - col stays frozen.
  - Each edge with row==row_snap increments cnt.
  - Any edge with row≠row_snap (bounce) returns to SCAN. col resumes from the same column, and its hold count restarts.
  - On the edge where cnt would reach DEBOUNCE_CYCLES, the key is accepted and the state moves to HELD.
  - With DEBOUNCE_CYCLES=1, acceptance happens on the detect edge itself.
- Accept actions:
  - row_idx = lowest set bit of row_snap (multiple rows in one column resolve to the lowest row).
  - If key_valid==0, or key_valid & key_ready on this edge: load key_code, set key_valid=1.
  - Otherwise: keep the old key_code, pulse overrun for one cycle, drop the new key.
- Handshake:
  - key_valid deasserts on the edge where key_valid & key_ready, unless a new accept occurs on that same edge (the new key is loaded and key_valid stays 1).
  - key_code is stable while key_valid=1.
  - key_ready with key_valid=0 has no effect.
- HELD state: col frozen. The first edge with row==0 sets cnt=1 and enters DEB_RELEASE. Holding the key never re-emits a code (no auto-repeat).
- DEB_RELEASE state:
  - Edges with row==0 increment cnt.
  - An edge with row≠0 returns to HELD.
  - When cnt reaches DEBOUNCE_CYCLES, go to SCAN with col advanced to the next column (wrap applies).
- Latency: with the key steady from first detection, key_valid is high DEBOUNCE_CYCLES-1 edges after the detect edge, i.e. visible the cycle after the accept edge.
- Keys in other columns are not seen while the state is not SCAN.
- Counter width: clog2(max(SCAN_HOLD, DEBOUNCE_CYCLES)+1). Counters saturate and never wrap.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {SCAN, DEB_PRESS, HELD, DEB_RELEASE};
  - a clog2 function;
  - a lowest-set-bit priority-encode function.
- One sub-module, key_debounce_counter: a compare-and-count block with clear, increment-on-match and a terminal-count flag. It is instantiated once and shared by the press and release phases.

Test Plan:
- Reset: assert rst for 3 cycles with row=4'b0100 → col=4'b0001, key_valid=0, overrun=0, busy=0; then col steps 0001→0010→0100→1000→0001 every 2 cycles.
- Clean press of key 9: row[2]=1 only while col=4'b0010, held for 10 cycles → key_code=9, key_valid=1 after 3 edges following detection; no second code while held; after release plus 4 cycles with row==0, col=4'b0100.
- Bounce: row[1] high for 2 cycles then low during DEB_PRESS → no key_valid, state returns to SCAN, col resumes at the same column.
- Handshake and overrun:
  - key_ready=0; press key 5, release, then press key 14 → key_code stays 5, overrun pulses once.
  - Then key_ready=1 for 1 cycle → key_valid=0.
- Multi-row: row=4'b1010 while col=4'b0001 → key_code=4 (row 1, column 0).
- Reset mid-operation: assert rst during DEB_PRESS, and separately with key_valid=1 → next cycle state SCAN, key_valid=0, col=4'b0001.
